// File: rtl/bus_rr_mux.sv
// bus_rr_mux: NCH-input, WIDTH-bit valid/ready bus multiplexer with a
// single registered output slot. It selects either a fixed channel (sel)
// or the next requester in round-robin order.
module bus_rr_mux #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        out_ch
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned IW = SELW + 1;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [NCH-1:0]   grant;
    logic             found;
    logic [IW-1:0]    rr_idx;
    logic             load_en;
    logic             xfer;
    logic [SELW-1:0]  xfer_ch;
    logic [WIDTH-1:0] xfer_data;
    logic [IW-1:0]    ptr_next;

    // Grant: fixed channel in mode 0, first requester from ptr onward in mode 1.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == SELW'(i)) begin
                    grant[i] = in_valid[i];
                end
            end
        end else begin
            for (int unsigned j = 0; j < NCH; j++) begin
                rr_idx = {1'b0, ptr_q} + IW'(j);
                if (rr_idx >= IW'(NCH)) begin
                    rr_idx = rr_idx - IW'(NCH);
                end
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (!found && (rr_idx == IW'(i)) && in_valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    // The slot can take a word when empty or when its content drains this cycle.
    assign load_en  = ~out_valid_q | out_ready;
    assign in_ready = grant & {NCH{load_en & ~rst}};
    assign xfer     = |in_ready;

    // Index and data of the (at most one) transferring channel.
    always_comb begin
        xfer_ch   = '0;
        xfer_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (in_ready[i]) begin
                xfer_ch   = SELW'(i);
                xfer_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output slot and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        ptr_next    = {1'b0, xfer_ch} + IW'(1);
        if (ptr_next >= IW'(NCH)) begin
            ptr_next = '0;
        end
        if (xfer) begin
            out_data_d  = xfer_data;
            out_ch_d    = xfer_ch;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = ptr_next[SELW-1:0];
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/bus_rr_mux.md
Name: bus_rr_mux

Overview:
- Parametrised successor to the team's combinational 2:1 bus select: an NCH-input, WIDTH-bit bus multiplexer with a registered output.
- Each input and the output use a valid/ready handshake.
- Two selection modes: fixed channel select (the legacy behaviour, now registered) and round-robin arbitration across all requesting channels.
- Sits between several bus producers and one shared consumer.

Parameters:
WIDTH, 4, data bus width in bits (>=1)
NCH, 4, number of input channels (2..8)
SELW, 2, select/channel-index width; must equal clog2(NCH); not checked in RTL

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel data valid
in_ready  output  NCH  per-channel accept; combinational
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SELW  channel index used when mode=0
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  consumer accept
out_ch  output  SELW  registered index of the channel that supplied out_data

Behaviour:
- Single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0 (channel 0 highest priority).
- in_ready=0 during the reset cycle.
- Output stage: one register slot.
  - load_en = ~out_valid | out_ready, i.e. the slot is empty or is being drained this cycle.
- Grant, combinational, one-hot or zero:
  - mode=0: grant[sel]=in_valid[sel]. If sel>=NCH, no grant and nothing is ever accepted.
  - mode=1: the first channel with in_valid=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap-around modulo NCH).
- in_ready[i] = grant[i] & load_en & ~rst. At most one in_ready bit is high in any cycle.
- Transfer: at most one input transfer per cycle, when in_valid[i]&in_ready[i]. On that edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Drain: out_valid&out_ready with no new transfer on the same edge -> out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load in one cycle is allowed. This gives full throughput: 1 word/cycle, latency 1 cycle from input transfer to out_valid.
- Round-robin pointer: on a transfer from channel k in mode=1, ptr <= (k+1) mod NCH. ptr is unchanged in mode=0 and on cycles without a transfer.
- Backpressure: while out_valid=1 and out_ready=0:
  - all in_ready=0;
  - out_data, out_valid and out_ch are held stable;
  - the grant may change freely (it is not latched).
- Mode or sel change: takes effect on the next grant evaluation (combinational). Data already in the output register is unaffected.
- No requests: no transfer; ptr held.
- Reset mid-operation: any word in the output register is discarded; out_valid=0 on the cycle after rst is sampled high.
- No data-width arithmetic. The channel slice index is i*WIDTH and must be computed at elaboration with constant widths.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset.
- Fixed mode, WIDTH=4, NCH=4: mode=0, sel=2, ch2=4'hA, all in_valid=1, out_ready=1 -> only in_ready[2]=1; next cycle out_data=4'hA, out_ch=2. Then sel=3 (ch3=4'h5) -> out_data=4'h5, out_ch=3. Then sel held at 2 with in_valid[2]=0 -> out_valid=0.
- Round-robin fairness: mode=1, all 4 channels always valid with data 4'h1/2/3/4, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1.
- Round-robin skip and wrap: mode=1, only ch1 and ch3 valid, out_ready=1 -> out_ch sequence 1,3,1,3. Then ch3 only -> 3,3,3.
- Backpressure: mode=1, word 4'h7 from ch0 in output, out_ready=0 for 3 cycles -> out_data=4'h7, out_ch=0 held; all in_ready=0. Raise out_ready -> the next channel (ptr=1) is loaded on the same edge the 4'h7 drains.
- Reset mid-stream: during the fairness test, assert rst for 1 cycle -> out_valid=0 next cycle; after release the first grant goes to ch0 (ptr reset to 0).
